// File: rtl/rr_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// rr_reg_write_arbiter
//
// Round-robin write controller for one shared, enable-gated W-bit register
// that resets to PRESET_VAL. N producers raise level requests. The controller
// grants one of them for a single cycle. On the following edge it loads that
// requester's data slice into the register and pulses a one-cycle acknowledge.
// If the requester has dropped its request by then, the write is abandoned.
// The highest priority then passes to the index after the winner.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   req[N]    level write request per requester
//   din[N*W]  packed write data, slice i = din[i*W +: W]
//   gnt[N]    registered one-hot grant (high during the GRANT cycle)
//   ack[N]    registered one-hot write-done pulse, one cycle wide
//   q[W]      shared register contents
//   busy      high while a grant is outstanding
//   wr_count  count of completed writes, wraps at 256
// -----------------------------------------------------------------------------
module rr_reg_write_arbiter #(
  parameter int             N          = 4,
  parameter int             W          = 8,
  parameter logic [W-1:0]   PRESET_VAL = {W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   din,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     ack,
  output logic [W-1:0]     q,
  output logic             busy,
  output logic [7:0]       wr_count
);

  localparam int PW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;         // index holding the highest priority
  logic [PW-1:0] win;         // requester granted in the current GRANT cycle
  logic [PW-1:0] pick;        // first eligible index at or after ptr
  logic          pick_valid;
  logic [N-1:0]  eligible;
  int            idx;

  // A requester being acknowledged this cycle still shows its old request
  // level. It is masked out here so that it is not granted a second time.
  assign eligible = req & ~ack;

  // Rotating priority search. The loop walks from the lowest priority to the
  // highest, so the last hit it records is the first eligible index from ptr.
  // NOTE: every signal driven here gets a default before the loop; a missing
  // default on any path would infer a latch.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (eligible[idx]) begin
        pick       = PW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  // NOTE: all state below is updated with non-blocking assignments. Every
  // flop then samples the pre-edge values, as the hardware does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      gnt      <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      q        <= PRESET_VAL;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (pick_valid) begin
            gnt   <= N'(1) << pick;
            win   <= pick;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end

        GRANT: begin
          // A withdrawn request abandons the write. The register, pointer and
          // counter are left untouched, so the same requester keeps priority.
          if (req[win]) begin
            q        <= din[win*W +: W];
            ack      <= N'(1) << win;
            ptr      <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
            wr_count <= wr_count + 8'd1;
          end
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_reg_write_arbiter
//
// Self-checking bench for rr_reg_write_arbiter (N=4, W=8). It covers the
// reset values, a directed vector table (single request, full contention,
// withdraw), a reset asserted mid-grant, the counter wrap, and a randomized
// run checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_rr_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] din = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic           busy;
  logic [7:0]     wr_count;

  rr_reg_write_arbiter #(.N(N), .W(W), .PRESET_VAL(8'hFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .ack      (ack),
    .q        (q),
    .busy     (busy),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. It tracks whether a grant is pending and whom it is for,
  // and it applies the arbitration rules as a search over indices mod N.
  // ---------------------------------------------------------------------------
  logic [W-1:0] m_q;
  logic [N-1:0] m_gnt, m_ack;
  logic         m_busy;
  int           m_cnt, m_ptr, m_w;
  bit           m_pending;

  function automatic void model_reset();
    m_q       = 8'hFF;
    m_gnt     = '0;
    m_ack     = '0;
    m_busy    = 1'b0;
    m_cnt     = 0;
    m_ptr     = 0;
    m_w       = 0;
    m_pending = 1'b0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] r, input logic [N*W-1:0] d);
    logic [N-1:0] elig;
    int           cand;
    bit           found;
    if (!m_pending) begin
      elig  = r & ~m_ack;
      m_ack = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (!found && elig[cand]) begin
          found     = 1'b1;
          m_w       = cand;
          m_gnt     = '0;
          m_gnt[cand] = 1'b1;
          m_busy    = 1'b1;
          m_pending = 1'b1;
        end
      end
    end else begin
      if (r[m_w]) begin
        m_q        = d[m_w*W +: W];
        m_ack      = '0;
        m_ack[m_w] = 1'b1;
        m_ptr      = (m_w + 1) % N;
        m_cnt      = (m_cnt + 1) % 256;
      end
      m_gnt     = '0;
      m_busy    = 1'b0;
      m_pending = 1'b0;
    end
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".gnt"},      32'(gnt),      32'(m_gnt));
    check({tag, ".ack"},      32'(ack),      32'(m_ack));
    check({tag, ".q"},        32'(q),        32'(m_q));
    check({tag, ".busy"},     32'(busy),     32'(m_busy));
    check({tag, ".wr_count"}, 32'(wr_count), 32'(m_cnt));
  endtask

  // Apply inputs, take one clock edge, update the model, and return 1 ns
  // later so that outputs are sampled away from the edge.
  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d);
    req = r;
    din = d;
    @(posedge clk);
    if (rst) model_edge(r, d);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs for one cycle and the outputs expected
  // after that cycle's edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           busy;
    logic [7:0]     cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    logic [N*W-1:0] rd;
    logic [N-1:0]   rr;

    // single request on index 2, then drop it on ack
    vecs[0]  = '{1'b1, 4'b0100, 32'h005A_0000, 4'b0100, 4'b0000, 8'hFF, 1'b1, 8'd0};
    vecs[1]  = '{1'b1, 4'b0100, 32'h005A_0000, 4'b0000, 4'b0100, 8'h5A, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 4'b0000, 32'h005A_0000, 4'b0000, 4'b0000, 8'h5A, 1'b0, 8'd1};
    vecs[3]  = '{1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 8'h5A, 1'b0, 8'd1};
    // reset brings ptr back to 0
    vecs[4]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 8'hFF, 1'b0, 8'd0};
    // full contention: grants rotate 0,1,2,3,0
    vecs[5]  = '{1'b1, 4'b1111, 32'h4433_2211, 4'b0001, 4'b0000, 8'hFF, 1'b1, 8'd0};
    vecs[6]  = '{1'b1, 4'b1111, 32'h4433_2211, 4'b0000, 4'b0001, 8'h11, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 4'b1111, 32'h4433_2211, 4'b0010, 4'b0000, 8'h11, 1'b1, 8'd1};
    vecs[8]  = '{1'b1, 4'b1111, 32'h4433_2211, 4'b0000, 4'b0010, 8'h22, 1'b0, 8'd2};
    vecs[9]  = '{1'b1, 4'b1111, 32'h4433_2211, 4'b0100, 4'b0000, 8'h22, 1'b1, 8'd2};
    vecs[10] = '{1'b1, 4'b1111, 32'h4433_2211, 4'b0000, 4'b0100, 8'h33, 1'b0, 8'd3};
    vecs[11] = '{1'b1, 4'b1111, 32'h4433_2211, 4'b1000, 4'b0000, 8'h33, 1'b1, 8'd3};
    vecs[12] = '{1'b1, 4'b1111, 32'h4433_2211, 4'b0000, 4'b1000, 8'h44, 1'b0, 8'd4};
    vecs[13] = '{1'b1, 4'b1111, 32'h4433_2211, 4'b0001, 4'b0000, 8'h44, 1'b1, 8'd4};
    vecs[14] = '{1'b1, 4'b1111, 32'h4433_2211, 4'b0000, 4'b0001, 8'h11, 1'b0, 8'd5};
    // ptr=1: requester 1 is granted, then withdraws during GRANT
    vecs[15] = '{1'b1, 4'b0010, 32'h4433_2211, 4'b0010, 4'b0000, 8'h11, 1'b1, 8'd5};
    vecs[16] = '{1'b1, 4'b0000, 32'h4433_2211, 4'b0000, 4'b0000, 8'h11, 1'b0, 8'd5};
    // ptr is still 1, so 1 beats 0
    vecs[17] = '{1'b1, 4'b0011, 32'h4433_2211, 4'b0010, 4'b0000, 8'h11, 1'b1, 8'd5};
    vecs[18] = '{1'b1, 4'b0011, 32'h4433_2211, 4'b0000, 4'b0010, 8'h22, 1'b0, 8'd6};
    vecs[19] = '{1'b1, 4'b0001, 32'h4433_2211, 4'b0001, 4'b0000, 8'h22, 1'b1, 8'd6};
    vecs[20] = '{1'b1, 4'b0001, 32'h4433_2211, 4'b0000, 4'b0001, 8'h11, 1'b0, 8'd7};
    vecs[21] = '{1'b1, 4'b0000, 32'h4433_2211, 4'b0000, 4'b0000, 8'h11, 1'b0, 8'd7};

    // ---- reset held with random inputs ----
    model_reset();
    for (int i = 0; i < 3; i++) begin
      req = N'($urandom);
      din = $urandom;
      @(posedge clk);
      #1;
      check("rst.q",        32'(q),        32'hFF);
      check("rst.gnt",      32'(gnt),      32'h0);
      check("rst.ack",      32'(ack),      32'h0);
      check("rst.busy",     32'(busy),     32'h0);
      check("rst.wr_count", 32'(wr_count), 32'h0);
    end

    // ---- release, idle for 10 cycles ----
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step('0, $urandom);
      check("idle.gnt",  32'(gnt),  32'h0);
      check("idle.ack",  32'(ack),  32'h0);
      check("idle.q",    32'(q),    32'hFF);
      check("idle.busy", 32'(busy), 32'h0);
      check("idle.cnt",  32'(wr_count), 32'h0);
    end

    // ---- directed table ----
    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst;
      if (!rst) model_reset();
      step(vecs[i].req, vecs[i].din);
      check($sformatf("vec%0d.gnt", i),  32'(gnt),      32'(vecs[i].gnt));
      check($sformatf("vec%0d.ack", i),  32'(ack),      32'(vecs[i].ack));
      check($sformatf("vec%0d.q", i),    32'(q),        32'(vecs[i].q));
      check($sformatf("vec%0d.busy", i), 32'(busy),     32'(vecs[i].busy));
      check($sformatf("vec%0d.cnt", i),  32'(wr_count), 32'(vecs[i].cnt));
      rst = 1'b1;
    end

    // ---- reset asserted mid-grant ----
    step(4'b0001, 32'h0000_00A5);
    check("midrst.busy_before", 32'(busy), 32'h1);
    check("midrst.gnt_before",  32'(gnt),  32'h1);
    #1;
    rst = 1'b0;
    model_reset();
    #1;  // well before the next rising edge
    check("midrst.gnt", 32'(gnt),  32'h0);
    check("midrst.q",   32'(q),    32'hFF);
    check("midrst.busy",32'(busy), 32'h0);
    check("midrst.cnt", 32'(wr_count), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step('0, 32'h0000_00A5);
      check("midrst.ack_after", 32'(ack), 32'h0);
      check("midrst.q_after",   32'(q),   32'hFF);
    end

    // ---- counter wrap: 256 writes from one requester, 3 cycles each ----
    for (int i = 0; i < 3 * 256; i++) begin
      step(4'b0001, $urandom);
      compare_model("wrap");
    end
    check("wrap.cnt0", 32'(wr_count), 32'h0);
    step(4'b0001, 32'h0000_00C3);
    step(4'b0001, 32'h0000_00C3);
    check("wrap.cnt1", 32'(wr_count), 32'h1);
    check("wrap.ack",  32'(ack),      32'h1);
    check("wrap.q",    32'(q),        32'hC3);
    step('0, 32'h0);
    compare_model("wrap.tail");

    // ---- randomized run against the model ----
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        model_reset();
        step('0, $urandom);
        rst = 1'b1;
      end else begin
        rr = N'($urandom);
        rd = $urandom;
        step(rr, rd);
      end
      compare_model("rand");
      check("rand.gnt_onehot0", 32'($countones(gnt) > 1), 32'h0);
      check("rand.ack_onehot0", 32'($countones(ack) > 1), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_reg_write_arbiter.md
Name: rr_reg_write_arbiter

Overview:
Round-robin controller that shares one enable-gated, preset-able W-bit register among N requesters. It arbitrates write requests, drives the register's enable and data select for one winner at a time, and returns a one-cycle acknowledge. The register resets to a preset value. The block sits between several producer blocks and a single shared state register in the sequential-circuits datapath.

Parameters:
N, 4, number of requesters (N >= 2)
W, 8, width of shared register and of each requester's data slice
PRESET_VAL, {W{1'b1}}, value loaded into q on reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req  input  N  write request per requester, level
din  input  N*W  packed data; slice i = din[i*W +: W]
gnt  output  N  one-hot grant, registered
ack  output  N  one-hot write-done pulse, registered
q  output  W  shared register contents
busy  output  1  high while in GRANT state
wr_count  output  8  count of completed writes, wraps

Behaviour:
- Reset is asynchronous. While rst=0: q=PRESET_VAL, gnt=0, ack=0, busy=0, wr_count=0, ptr=0, state=IDLE. Reset asserted mid-GRANT aborts the write: no load, no ack.
- The internal priority pointer ptr is in [0, N-1]. Priority order is ptr, ptr+1, ..., wrapping mod N.
- Eligible mask = req & ~ack. A requester whose ack is high this cycle cannot win this cycle, which prevents a re-grant on a stale req.
- State IDLE:
  - If the eligible mask is nonzero, the next edge sets gnt to onehot(w), where w is the first eligible index from ptr. State goes to GRANT and busy=1.
  - Otherwise all outputs hold. ack is cleared to 0 on every IDLE edge.
- State GRANT (exactly 1 cycle), w latched. At the next edge:
  - If req[w]=1: q<=din[w], ack<=onehot(w), ptr<=(w+1) mod N, wr_count<=wr_count+1 (8-bit wrap).
  - If req[w]=0 (withdrawn): no load, ack stays 0, ptr and wr_count unchanged.
  - In both cases: gnt<=0, busy<=0, state<=IDLE.
- Latency: req sampled at edge k, then gnt high during cycle k..k+1, then q updated and ack high after edge k+1. The maximum write rate is one write per 2 cycles.
- Requesters hold req and their din slice stable from req assertion until ack. din of non-granted requesters is ignored.
- gnt is always one-hot or zero. ack is always one-hot or zero and lasts exactly one cycle.
- Simultaneous requests resolve by the rotating pointer only. No requester waits more than N grants.
- q changes only on a successful GRANT edge or on reset.

Test Plan:
- Reset: hold rst=0 with random req/din -> q=8'hFF, gnt=0, ack=0, busy=0, wr_count=0. Release rst, no req -> all outputs hold for 10 cycles.
- Single request: req=4'b0100, din slice2=8'h5A -> next edge gnt=4'b0100 and busy=1. The following edge gives q=8'h5A, ack=4'b0100 for 1 cycle, wr_count=1. Drop req on ack -> no re-grant.
- Full contention: req=4'b1111 held, slices 0..3 = 8'h11, 8'h22, 8'h33, 8'h44 -> grants go 0,1,2,3,0,... with each grant 2 cycles apart. q follows 11,22,33,44,11 and ack is never on the same index twice in a row.
- Withdraw: ptr=1, req=4'b0010, deassert req[1] during GRANT -> q unchanged, no ack, wr_count unchanged. Re-assert req=4'b0011 -> requester 1 wins first, since ptr is still 1.
- Reset mid-grant: drive rst=0 while busy=1 -> gnt=0 and q=8'hFF immediately, without waiting for a clock. No ack after release.
- Counter wrap: 256 successful single-requester writes -> wr_count returns to 0, and the 257th write gives wr_count=1.
